// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: registered circular buffer, no fall-through (push visible at head next cycle).
// Backpressure: if_ready drops only when full, independent of id_ready; flush empties the queue on the next edge.
module if_id_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_pc_next,
  input  logic                     if_exc_req,
  input  logic [3:0]               if_exc_code,
  input  logic                     if_irq_req,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc_next,
  output logic                     id_exc_req,
  output logic [3:0]               id_exc_code,
  output logic                     id_irq_req,
  input  logic                     id_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        exc_req;
    logic [3:0]  exc_code;
    logic        irq_req;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign if_ready = (count != CW'(DEPTH));
  assign id_valid = (count != '0) & ~flush;
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= '{instr:    if_instr,
                       pc:       if_pc,
                       pc_next:  if_pc_next,
                       exc_req:  if_exc_req,
                       exc_code: if_exc_code,
                       irq_req:  if_irq_req};
    end
  end

  always_comb begin
    id_instr    = NOP_INSTR;
    id_pc       = '0;
    id_pc_next  = '0;
    id_exc_req  = 1'b0;
    id_exc_code = '0;
    id_irq_req  = 1'b0;
    if (count != '0) begin
      id_instr    = mem[rd_ptr].instr;
      id_pc       = mem[rd_ptr].pc;
      id_pc_next  = mem[rd_ptr].pc_next;
      id_exc_req  = mem[rd_ptr].exc_req;
      id_exc_code = mem[rd_ptr].exc_code;
      id_irq_req  = mem[rd_ptr].irq_req;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: vector table plus hand sequences, checked against a queue scoreboard.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_pc_next = '0;
  logic        if_exc_req = 1'b0;
  logic [3:0]  if_exc_code = '0;
  logic        if_irq_req = 1'b0;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic        id_exc_req;
  logic [3:0]  id_exc_code;
  logic        id_irq_req;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
    .if_exc_req(if_exc_req), .if_exc_code(if_exc_code), .if_irq_req(if_irq_req),
    .if_ready(if_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_next(id_pc_next), .id_exc_req(id_exc_req), .id_exc_code(id_exc_code),
    .id_irq_req(id_irq_req), .id_ready(id_ready), .flush(flush), .count(count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        exc;
    logic [3:0]  code;
    logic        irq;
  } ent_t;

  typedef struct {
    logic        r;
    logic        v;
    ent_t        e;
    logic        rdy;
    logic        fl;
    int          cnt_after;
  } vec_t;

  ent_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic exc, input logic [3:0] code,
                              input logic irq);
    ent_t e;
    e.instr   = {pc[19:0], 12'h093};
    e.pc      = pc;
    e.pc_next = pc + 32'd4;
    e.exc     = exc;
    e.code    = code;
    e.irq     = irq;
    return e;
  endfunction

  function automatic vec_t mv(input logic r, input logic v, input logic [31:0] pc,
                              input logic rdy, input logic fl, input int cnt);
    vec_t t;
    t.r = r; t.v = v; t.e = mk(pc, 1'b0, 4'h0, 1'b0);
    t.rdy = rdy; t.fl = fl; t.cnt_after = cnt;
    return t;
  endfunction

  // One cycle: drive after negedge, check the settled outputs against the scoreboard, then update it.
  task automatic step(input logic r, input logic v, input ent_t e, input logic rdy, input logic fl);
    logic can_push;
    @(negedge clk);
    rst_n = r; if_valid = v; if_instr = e.instr; if_pc = e.pc; if_pc_next = e.pc_next;
    if_exc_req = e.exc; if_exc_code = e.code; if_irq_req = e.irq; id_ready = rdy; flush = fl;
    #2;
    chk("count", 32'(count), 32'(sb.size()));
    chk("if_ready", 32'(if_ready), 32'(sb.size() != DEPTH));
    chk("id_valid", 32'(id_valid), 32'(sb.size() != 0 && !fl));
    if (sb.size() != 0) begin
      chk("id_instr", id_instr, sb[0].instr);
      chk("id_pc", id_pc, sb[0].pc);
      chk("id_pc_next", id_pc_next, sb[0].pc_next);
      chk("id_exc_req", 32'(id_exc_req), 32'(sb[0].exc));
      chk("id_exc_code", 32'(id_exc_code), 32'(sb[0].code));
      chk("id_irq_req", 32'(id_irq_req), 32'(sb[0].irq));
    end else begin
      chk("empty_instr", id_instr, NOP);
      chk("empty_pc", id_pc, 32'h0);
      chk("empty_pc_next", id_pc_next, 32'h0);
      chk("empty_flags", {26'h0, id_exc_req, id_exc_code, id_irq_req}, 32'h0);
    end
    if (!r || fl) begin
      sb.delete();
    end else begin
      can_push = (sb.size() != DEPTH);
      if (rdy && sb.size() != 0) void'(sb.pop_front());
      if (v && can_push) sb.push_back(e);
    end
  endtask

  task automatic after_cnt(input string name, input int exp);
    @(posedge clk);
    #1;
    chk(name, 32'(count), 32'(exp));
  endtask

  initial begin
    ent_t idle;
    idle = mk(32'h0, 1'b0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);

    // reset, single push/pop, fill to full, rejected fifth push, drain
    tbl.push_back(mv(0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mv(1, 0, 32'h0, 1, 0, 0));
    tbl.push_back(mv(1, 1, 32'h8000_0000, 0, 0, 1));
    tbl.push_back(mv(1, 0, 32'h0, 0, 0, 1));
    tbl.push_back(mv(1, 0, 32'h0, 1, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mv(1, 1, 32'h8000_0010 + 32'(4 * i), 0, 0, i + 1));
    tbl.push_back(mv(1, 1, 32'h8000_0020, 0, 0, 4));
    for (int i = 0; i < 4; i++) tbl.push_back(mv(1, 0, 32'h0, 1, 0, 3 - i));
    tbl.push_back(mv(1, 0, 32'h0, 0, 0, 0));
    // exception entry between two normal ones; last one carries irq
    tbl.push_back(mv(1, 1, 32'h0000_0100, 0, 0, 1));
    tbl.push_back(mv(1, 1, 32'h0000_0104, 0, 0, 2));
    tbl[$].e = mk(32'h0000_0104, 1'b1, 4'h0, 1'b0);
    tbl.push_back(mv(1, 1, 32'h0000_0108, 0, 0, 3));
    tbl[$].e = mk(32'h0000_0108, 1'b0, 4'h5, 1'b1);
    for (int i = 0; i < 3; i++) tbl.push_back(mv(1, 0, 32'h0, 1, 0, 2 - i));
    // full with id_ready: pop only, freed slot taken next cycle
    for (int i = 0; i < 4; i++) tbl.push_back(mv(1, 1, 32'h9000_0000 + 32'(4 * i), 0, 0, i + 1));
    tbl.push_back(mv(1, 1, 32'h9000_0040, 1, 0, 3));
    tbl.push_back(mv(1, 1, 32'h9000_0044, 0, 0, 4));
    for (int i = 0; i < 4; i++) tbl.push_back(mv(1, 0, 32'h0, 1, 0, 3 - i));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].e, tbl[i].rdy, tbl[i].fl);
      after_cnt("vec_count", tbl[i].cnt_after);
    end

    // steady push+pop at count=2 across pointer wrap
    step(1, 1, mk(32'hA000_0000, 0, 4'h0, 0), 0, 0);
    step(1, 1, mk(32'hA000_0004, 0, 4'h0, 0), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, mk(32'hA000_0100 + 32'(4 * i), 0, 4'h0, 0), 1, 0);
      after_cnt("wrap_count", 2);
    end
    step(1, 0, idle, 1, 0);
    step(1, 0, idle, 1, 0);
    after_cnt("wrap_drain", 0);

    // flush at count=3 with a concurrent push
    for (int i = 0; i < 3; i++) step(1, 1, mk(32'hB000_0000 + 32'(4 * i), 0, 4'h0, 0), 0, 0);
    step(1, 1, mk(32'hB000_00F0, 0, 4'h0, 0), 1, 1);
    after_cnt("flush_count", 0);
    step(1, 0, idle, 0, 0);
    step(1, 1, mk(32'hB000_0200, 0, 4'h0, 0), 0, 0);
    step(1, 0, idle, 1, 0);
    after_cnt("post_flush", 0);

    // reset mid-operation at count=3
    for (int i = 0; i < 3; i++) step(1, 1, mk(32'hC000_0000 + 32'(4 * i), 0, 4'h0, 0), 0, 0);
    step(0, 1, mk(32'hC000_00F0, 0, 4'h0, 0), 1, 0);
    after_cnt("reset_count", 0);
    step(1, 0, idle, 0, 0);
    step(1, 1, mk(32'hC000_0100, 0, 4'h0, 0), 0, 0);
    step(1, 0, idle, 1, 0);
    after_cnt("post_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; SHALL be a power of two, 2..8.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction presented on id_instr when the queue is empty.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 if_valid  input  1  fetch presents a valid instruction.
REQ-006 if_instr  input  32  fetched instruction word.
REQ-007 if_pc  input  32  PC of the fetched instruction.
REQ-008 if_pc_next  input  32  predicted next PC.
REQ-009 if_exc_req  input  1  fetch exception flag.
REQ-010 if_exc_code  input  4  fetch exception code.
REQ-011 if_irq_req  input  1  interrupt-pending flag.
REQ-012 if_ready  output  1  queue accepts a push this cycle.
REQ-013 id_valid  output  1  head entry valid for decode.
REQ-014 id_instr, id_pc, id_pc_next  output  32 each  head entry fields.
REQ-015 id_exc_req  output  1; id_exc_code  output  4; id_irq_req  output  1  head entry flags.
REQ-016 id_ready  input  1  decode consumes the head this cycle.
REQ-017 flush  input  1  discard all entries (redirect from EXE/CSR).
REQ-018 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Push SHALL occur when if_valid & if_ready & ~flush; pop SHALL occur when id_valid & id_ready & ~flush.
REQ-020 Entry storage SHALL be a circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-021 if_ready SHALL be (count != DEPTH) and SHALL NOT depend on id_ready.
REQ-022 id_valid SHALL be (count != 0) & ~flush.
REQ-023 There SHALL be no fall-through path: a pushed entry is visible at the head no earlier than the cycle after the push (latency 1).
REQ-024 Pushes SHALL be FIFO ordered; all fields of an entry (instr, pc, pc_next, exc_req, exc_code, irq_req) SHALL travel together.
REQ-025 Push without pop SHALL increment count; pop without push SHALL decrement count; push and pop together SHALL leave count unchanged and advance both pointers.
REQ-026 When empty, id_instr SHALL be NOP_INSTR and id_exc_req and id_irq_req SHALL be 0; id_pc, id_pc_next and id_exc_code SHALL be 0.
REQ-027 Flush SHALL take priority over push and pop: on the next edge, count, write pointer and read pointer SHALL all be 0.
REQ-028 During a flush cycle, if_valid SHALL be ignored.
REQ-029 An entry with exc_req=1 SHALL be queued and popped like any other entry; the queue SHALL NOT drop or reorder it.
REQ-030 When full with id_ready=1, a pop SHALL occur and if_ready SHALL remain 0 that cycle; the freed slot SHALL accept a push from the following cycle.

Reset
REQ-031 With rst_n=0 at an edge, count, both pointers and all valid state SHALL be 0, including mid-operation.
REQ-032 In the cycle after reset: if_ready=1, id_valid=0, id_instr=NOP_INSTR, id_exc_req=0, id_irq_req=0.
REQ-033 Storage data arrays need not be reset.

Verification
REQ-034 Reset, then push pc=0x8000_0000, instr=0x0000_0093 with id_ready=0 -> next cycle id_valid=1, id_pc=0x8000_0000, count=1.
REQ-035 Push 4 entries with id_ready=0 -> count=4, if_ready=0; a fifth if_valid is not accepted; then assert id_ready for 4 cycles -> pcs pop in push order, count=0, id_instr=NOP_INSTR.
REQ-036 At count=2, push and pop simultaneously for 10 cycles -> count stays 2 and pointers wrap correctly, with pc order preserved across the wrap.
REQ-037 At count=3, assert flush together with if_valid=1 -> id_valid=0 in that cycle; next cycle count=0 and the pushed entry is absent.
REQ-038 Push an entry with exc_req=1, exc_code=4'h0 between two normal entries -> it is popped second with its flags intact.
REQ-039 Assert rst_n=0 at count=3 -> next cycle count=0, if_ready=1, id_valid=0.
